// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: start, LSB-first data, optional parity, 1/2 stop bits
// Bit timing from an internal baud counter on sysclk; line output is registered.
module uart_tx #(
   parameter int SYSCLK    = 100_000_000,
   parameter int BAUD      = 115_200,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic                 sysclk_in,
   input  logic                 rst_in,
   input  logic                 tx_valid_in,
   input  logic [DATA_BITS-1:0] tx_data_in,
   output logic                 tx_ready_out,
   output logic                 tx_serial_out,
   output logic                 tx_done_out
);
   localparam int CLKS_PER_BIT = SYSCLK / BAUD;
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int BW = $clog2(DATA_BITS) + 1;
   localparam logic [CW-1:0] LAST_CNT  = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
   localparam logic          LAST_STOP = (STOP_BITS == 2);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;

   logic [2:0]           state;
   logic [CW-1:0]        baud_cnt;
   logic [BW-1:0]        bit_idx;
   logic                 stop_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 parity_bit;
   logic                 bit_end;

   assign bit_end = (baud_cnt == LAST_CNT);

   always_ff @(posedge sysclk_in) begin
      if (rst_in) begin
         state         <= S_IDLE;
         baud_cnt      <= '0;
         bit_idx       <= '0;
         stop_cnt      <= 1'b0;
         shreg         <= '0;
         parity_bit    <= 1'b0;
         tx_ready_out  <= 1'b0;
         tx_serial_out <= 1'b1;
         tx_done_out   <= 1'b0;
      end else begin
         tx_done_out <= 1'b0;

         // Line follows the state of the previous cycle, giving the one-edge output delay.
         case (state)
            S_START:  tx_serial_out <= 1'b0;
            S_DATA:   tx_serial_out <= shreg[0];
            S_PARITY: tx_serial_out <= parity_bit;
            default:  tx_serial_out <= 1'b1;
         endcase

         if (state != S_IDLE) begin
            baud_cnt <= bit_end ? '0 : baud_cnt + CW'(1);
         end

         case (state)
            S_IDLE: begin
               baud_cnt <= '0;
               if (tx_valid_in && tx_ready_out) begin
                  shreg        <= tx_data_in;
                  parity_bit   <= (PARITY == 1) ? ~(^tx_data_in) : (^tx_data_in);
                  bit_idx      <= '0;
                  stop_cnt     <= 1'b0;
                  tx_ready_out <= 1'b0;
                  state        <= S_START;
               end else begin
                  tx_ready_out <= 1'b1;
               end
            end
            S_START: begin
               if (bit_end) state <= S_DATA;
            end
            S_DATA: begin
               if (bit_end) begin
                  shreg <= {1'b0, shreg[DATA_BITS-1:1]};
                  if (bit_idx == LAST_BIT) begin
                     bit_idx <= '0;
                     state   <= (PARITY != 0) ? S_PARITY : S_STOP;
                  end else begin
                     bit_idx <= bit_idx + BW'(1);
                  end
               end
            end
            S_PARITY: begin
               if (bit_end) state <= S_STOP;
            end
            S_STOP: begin
               if (bit_end) begin
                  if (stop_cnt == LAST_STOP) begin
                     stop_cnt     <= 1'b0;
                     tx_done_out  <= 1'b1;
                     tx_ready_out <= 1'b1;
                     state        <= S_IDLE;
                  end else begin
                     stop_cnt <= 1'b1;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed bench for uart_tx across parity and stop-bit variants
// Four instances at 16 clocks per bit: 8N1, 8E1, 8O1 and 5N2.
module tb_uart_tx;
   logic       clk;
   logic       rst;
   logic [3:0] valid;
   logic [7:0] tx_data;
   wire  [3:0] rdy;
   wire  [3:0] ser;
   wire  [3:0] dn;

   int total = 0;
   int bad   = 0;

   uart_tx #(.SYSCLK(16), .BAUD(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
      .sysclk_in(clk), .rst_in(rst), .tx_valid_in(valid[0]), .tx_data_in(tx_data),
      .tx_ready_out(rdy[0]), .tx_serial_out(ser[0]), .tx_done_out(dn[0]));
   uart_tx #(.SYSCLK(16), .BAUD(1), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
      .sysclk_in(clk), .rst_in(rst), .tx_valid_in(valid[1]), .tx_data_in(tx_data),
      .tx_ready_out(rdy[1]), .tx_serial_out(ser[1]), .tx_done_out(dn[1]));
   uart_tx #(.SYSCLK(16), .BAUD(1), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
      .sysclk_in(clk), .rst_in(rst), .tx_valid_in(valid[2]), .tx_data_in(tx_data),
      .tx_ready_out(rdy[2]), .tx_serial_out(ser[2]), .tx_done_out(dn[2]));
   uart_tx #(.SYSCLK(16), .BAUD(1), .DATA_BITS(5), .PARITY(0), .STOP_BITS(2)) u_5n2 (
      .sysclk_in(clk), .rst_in(rst), .tx_valid_in(valid[3]), .tx_data_in(tx_data[4:0]),
      .tx_ready_out(rdy[3]), .tx_serial_out(ser[3]), .tx_done_out(dn[3]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Raise valid and wait (bounded) for the accepting edge; caller decides when to drop valid.
   task automatic send(input int idx, input logic [7:0] d, input string tag);
      int w = 0;
      tx_data    = d;
      valid[idx] = 1'b1;
      while (rdy[idx] !== 1'b1 && w < 400) begin
         tick();
         w++;
      end
      chk({tag, "_ready_wait"}, 32'(w < 400), 32'd1);
      tick();
   endtask

   // Called just after the accepting edge E; returns just after edge E+flen+1.
   task automatic check_frame(input int idx, input int nbits, input logic [11:0] expb,
                              input int flen, input string tag);
      int rdy_bad  = 0;
      int done_cnt = 0;
      int done_at  = -1;
      chk({tag, "_accept_rdy"}, 32'(rdy[idx]), 32'd0);
      chk({tag, "_line_at_accept"}, 32'(ser[idx]), 32'd1);
      for (int c = 1; c <= flen + 1; c++) begin
         tick();
         if (c == 1) chk({tag, "_start_edge"}, 32'(ser[idx]), 32'd0);
         if (c >= 9 && (c - 9) % 16 == 0 && (c - 9) / 16 < nbits)
            chk($sformatf("%s_bit%0d", tag, (c - 9) / 16), 32'(ser[idx]), 32'(expb[(c - 9) / 16]));
         if (c < flen && rdy[idx] !== 1'b0) rdy_bad++;
         if (dn[idx] === 1'b1) begin
            done_cnt++;
            done_at = c;
         end
         if (c == flen) chk({tag, "_ready_at_done"}, 32'(rdy[idx]), 32'd1);
      end
      chk({tag, "_done_count"}, 32'(done_cnt), 32'd1);
      chk({tag, "_done_at"}, 32'(done_at), 32'(flen));
      chk({tag, "_busy_ready"}, 32'(rdy_bad), 32'd0);
   endtask

   initial begin
      int no_done;
      rst     = 1'b1;
      valid   = 4'b0001;
      tx_data = 8'hA5;

      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("reset_ready_%0d", i), 32'(rdy), 32'h0);
         chk($sformatf("reset_line_%0d", i), 32'(ser), 32'hF);
         chk($sformatf("reset_done_%0d", i), 32'(dn), 32'h0);
      end
      rst = 1'b0;
      tick();
      chk("release_ready", 32'(rdy), 32'hF);
      tick();
      valid[0] = 1'b0;
      // 0xA5 8N1: 0,1,0,1,0,0,1,0,1,1
      check_frame(0, 10, 12'h34A, 160, "basic_a5");

      send(1, 8'hA5, "even_a5");
      valid[1] = 1'b0;
      check_frame(1, 11, 12'h54A, 176, "even_a5");

      send(2, 8'hA5, "odd_a5");
      valid[2] = 1'b0;
      check_frame(2, 11, 12'h74A, 176, "odd_a5");

      send(2, 8'h01, "odd_01");
      valid[2] = 1'b0;
      check_frame(2, 11, 12'h402, 176, "odd_01");

      send(3, 8'h1F, "stop2_1f");
      valid[3] = 1'b0;
      check_frame(3, 8, 12'h0FE, 128, "stop2_1f");

      // Back-to-back with data changed mid-frame.
      send(0, 8'h3C, "b2b_first");
      tx_data = 8'hC3;
      check_frame(0, 10, 12'h278, 160, "b2b_first");
      valid[0] = 1'b0;
      check_frame(0, 10, 12'h386, 160, "b2b_second");

      // Reset during data bit 3 of 0xFF.
      send(0, 8'hFF, "abort_ff");
      valid[0] = 1'b0;
      for (int c = 1; c < 70; c++) tick();
      rst = 1'b1;
      tick();
      chk("abort_line", 32'(ser[0]), 32'd1);
      chk("abort_done", 32'(dn[0]), 32'd0);
      chk("abort_ready", 32'(rdy[0]), 32'd0);
      rst = 1'b0;
      no_done = 0;
      for (int c = 0; c < 200; c++) begin
         tick();
         if (dn[0] === 1'b1) no_done++;
      end
      chk("abort_no_done", 32'(no_done), 32'd0);
      chk("abort_idle_line", 32'(ser[0]), 32'd1);

      send(0, 8'h5A, "after_abort");
      valid[0] = 1'b0;
      check_frame(0, 10, 12'h2B4, 160, "after_abort");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
